// File: rtl/single_cycle_processor.sv
// Single-cycle ARMv4 subset core: data-processing, LDR/STR immediate offset, B.
// Instruction and data memories are external and combinational.
module single_cycle_processor #(
   parameter int unsigned     WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction,
   input  logic [WIDTH-1:0] read_data,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] direction,
   output logic [WIDTH-1:0] write_data,
   output logic             mem_write
);

   typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_NOP = 2'b11} op_t;
   typedef enum logic [3:0] {
      CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
      CMD_CMP = 4'b1010, CMD_ORR = 4'b1100
   } cmd_t;
   typedef enum logic [3:0] {
      C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3, C_MI = 4'h4,
      C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7, C_HI = 4'h8, C_LS = 4'h9,
      C_GE = 4'hA, C_LT = 4'hB, C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE
   } cond_t;

   logic [WIDTH-1:0] regs [15];
   logic             flag_n, flag_z, flag_c, flag_v;

   op_t              op;
   cmd_t             cmd;
   cond_t            cond;
   logic [3:0]       rn, rd, rm;
   logic [WIDTH-1:0] pc_plus4, pc_plus8, rn_val, rd_val, rm_val;
   logic [WIDTH-1:0] imm_ext, imm_rot, branch_off, alu_b, alu_res, wb_val, next_pc;
   logic [2*WIDTH-1:0] imm_dbl;
   logic [WIDTH:0]   sum_full;
   logic             alu_sub, cond_ok, dp_known, logic_op;
   logic             reg_write, flag_write, res_n, res_z, res_c, res_v;

   assign op    = op_t'(instruction[27:26]);
   assign cmd   = cmd_t'(instruction[24:21]);
   assign cond  = cond_t'(instruction[31:28]);
   assign rn    = instruction[19:16];
   assign rd    = instruction[15:12];
   assign rm    = instruction[3:0];

   // R15 is not stored; any read of it sees the pipeline-visible pc+8.
   assign pc_plus4 = pc + WIDTH'(4);
   assign pc_plus8 = pc + WIDTH'(8);
   assign rn_val   = (rn == 4'hF) ? pc_plus8 : regs[rn];
   assign rd_val   = (rd == 4'hF) ? pc_plus8 : regs[rd];
   assign rm_val   = (rm == 4'hF) ? pc_plus8 : regs[rm];

   assign imm_ext    = {{(WIDTH-8){1'b0}}, instruction[7:0]};
   assign imm_dbl    = {imm_ext, imm_ext} >> {instruction[11:8], 1'b0};
   assign imm_rot    = imm_dbl[WIDTH-1:0];
   assign branch_off = {{(WIDTH-26){instruction[23]}}, instruction[23:0], 2'b00};

   always_comb begin
      alu_b   = '0;
      alu_sub = 1'b0;
      case (op)
         OP_DP: begin
            alu_b   = instruction[25] ? imm_rot : (rm_val << instruction[11:7]);
            alu_sub = (cmd == CMD_SUB) || (cmd == CMD_CMP);
         end
         OP_MEM: begin
            alu_b   = {{(WIDTH-12){1'b0}}, instruction[11:0]};
            alu_sub = !instruction[23];
         end
         default: ;
      endcase
   end

   // Subtraction as a + ~b + 1 so the carry-out is the ARM no-borrow flag.
   assign sum_full = alu_sub ? ({1'b0, rn_val} + {1'b0, ~alu_b} + (WIDTH+1)'(1))
                             : ({1'b0, rn_val} + {1'b0, alu_b});

   always_comb begin
      alu_res = sum_full[WIDTH-1:0];
      if (op == OP_DP) begin
         case (cmd)
            CMD_AND: alu_res = rn_val & alu_b;
            CMD_ORR: alu_res = rn_val | alu_b;
            default: alu_res = sum_full[WIDTH-1:0];
         endcase
      end
   end

   assign res_n = alu_res[WIDTH-1];
   assign res_z = (alu_res == '0);
   assign res_c = sum_full[WIDTH];
   assign res_v = alu_sub ? ((rn_val[WIDTH-1] != alu_b[WIDTH-1]) && (sum_full[WIDTH-1] != rn_val[WIDTH-1]))
                          : ((rn_val[WIDTH-1] == alu_b[WIDTH-1]) && (sum_full[WIDTH-1] != rn_val[WIDTH-1]));

   always_comb begin
      case (cond)
         C_EQ: cond_ok = flag_z;
         C_NE: cond_ok = !flag_z;
         C_CS: cond_ok = flag_c;
         C_CC: cond_ok = !flag_c;
         C_MI: cond_ok = flag_n;
         C_PL: cond_ok = !flag_n;
         C_VS: cond_ok = flag_v;
         C_VC: cond_ok = !flag_v;
         C_HI: cond_ok = flag_c && !flag_z;
         C_LS: cond_ok = !flag_c || flag_z;
         C_GE: cond_ok = (flag_n == flag_v);
         C_LT: cond_ok = (flag_n != flag_v);
         C_GT: cond_ok = !flag_z && (flag_n == flag_v);
         C_LE: cond_ok = flag_z || (flag_n != flag_v);
         C_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign dp_known   = (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
                       (cmd == CMD_ORR) || (cmd == CMD_CMP);
   assign logic_op   = (cmd == CMD_AND) || (cmd == CMD_ORR);
   assign reg_write  = cond_ok && (rd != 4'hF) &&
                       (((op == OP_DP) && dp_known && (cmd != CMD_CMP)) ||
                        ((op == OP_MEM) && instruction[20]));
   assign flag_write = cond_ok && (op == OP_DP) && dp_known && (instruction[20] || (cmd == CMD_CMP));
   assign wb_val     = (op == OP_MEM) ? read_data : alu_res;
   assign next_pc    = (cond_ok && (op == OP_BR)) ? (pc_plus8 + branch_off) : pc_plus4;

   assign direction  = alu_res;
   assign write_data = rd_val;
   assign mem_write  = reset && cond_ok && (op == OP_MEM) && !instruction[20];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc     <= RESET_PC;
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
         for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
      end else begin
         pc <= next_pc;
         if (reg_write) regs[rd] <= wb_val;
         if (flag_write) begin
            flag_n <= res_n;
            flag_z <= res_z;
            // Logical ops leave C and V untouched.
            if (!logic_op) begin
               flag_c <= res_c;
               flag_v <= res_v;
            end
         end
      end
   end

endmodule

// File: tb/tb_single_cycle_processor.sv
// Directed-vector bench for single_cycle_processor; registers are observed
// through STR write_data and ALU results through direction.
module tb_single_cycle_processor;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] read_data;
   logic [31:0] pc;
   logic [31:0] direction;
   logic [31:0] write_data;
   logic        mem_write;

   int          compared;
   int          mismatched;
   logic [31:0] exp_pc;

   single_cycle_processor #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .instruction(instruction),
      .read_data  (read_data),
      .pc         (pc),
      .direction  (direction),
      .write_data (write_data),
      .mem_write  (mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   task automatic drive(input logic [31:0] i, input logic [31:0] r);
      instruction = i;
      read_data   = r;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      exp_pc = exp_pc + 32'd4;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(32'hE5944010, 32'h0);
      compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL reset_mw_ldr: got %b want 0", mem_write); end
      repeat (2) @(posedge clk);
      #1;
      compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc_hold: got %h want %h", pc, 32'h0); end
      drive(32'hE5049004, 32'h0);
      compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL reset_mw_str: got %b want 0", mem_write); end
      reset = 1'b1;
      #1;
      compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_release_pc: got %h want %h", pc, 32'h0); end
      exp_pc = 32'h0;
      @(posedge clk);
      #1;
      // the STR above executed once reset released: pc moves on, no reg change
      exp_pc = 32'h4;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      exp_pc = 32'h0;
   endtask

   task automatic test_ldr();
      drive(32'hE5949010, 32'hE5949010);
      compared++; if (direction !== 32'h00000010) begin mismatched++; $display("FAIL ldr1_dir: got %h want %h", direction, 32'h10); end
      compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL ldr1_mw: got %b want 0", mem_write); end
      tick();
      compared++; if (pc !== 32'h4) begin mismatched++; $display("FAIL ldr1_pc: got %h want %h", pc, 32'h4); end
      drive(32'hE5995010, 32'hE5949020);
      compared++; if (direction !== 32'hE5949020) begin mismatched++; $display("FAIL ldr2_dir: got %h want %h", direction, 32'hE5949020); end
      tick();
      compared++; if (pc !== 32'h8) begin mismatched++; $display("FAIL ldr2_pc: got %h want %h", pc, 32'h8); end
      drive(32'hE5951010, 32'h12345678);
      compared++; if (direction !== 32'hE5949030) begin mismatched++; $display("FAIL ldr3_dir: got %h want %h", direction, 32'hE5949030); end
      tick();
      compared++; if (pc !== 32'hC) begin mismatched++; $display("FAIL ldr3_pc: got %h want %h", pc, 32'hC); end
   endtask

   task automatic test_str();
      drive(32'hE5049004, 32'h0);
      compared++; if (mem_write !== 1'b1) begin mismatched++; $display("FAIL str_mw: got %b want 1", mem_write); end
      compared++; if (direction !== 32'hFFFFFFFC) begin mismatched++; $display("FAIL str_dir: got %h want %h", direction, 32'hFFFFFFFC); end
      compared++; if (write_data !== 32'hE5949010) begin mismatched++; $display("FAIL str_wd_r9: got %h want %h", write_data, 32'hE5949010); end
      tick();
      compared++; if (pc !== 32'h10) begin mismatched++; $display("FAIL str_pc: got %h want %h", pc, 32'h10); end
      drive(32'hE5841000, 32'h0);
      compared++; if (write_data !== 32'h12345678) begin mismatched++; $display("FAIL str_wd_r1: got %h want %h", write_data, 32'h12345678); end
      compared++; if (direction !== 32'h0) begin mismatched++; $display("FAIL str_dir_r4: got %h want %h", direction, 32'h0); end
      tick();
      drive(32'hE5845000, 32'h0);
      compared++; if (write_data !== 32'hE5949020) begin mismatched++; $display("FAIL str_wd_r5: got %h want %h", write_data, 32'hE5949020); end
      tick();
   endtask

   task automatic test_branch();
      logic [31:0] here;
      drive(32'hE2500000, 32'h0);
      compared++; if (direction !== 32'h0) begin mismatched++; $display("FAIL subs_dir: got %h want %h", direction, 32'h0); end
      tick();
      here = exp_pc;
      drive(32'h0AFFFFFE, 32'h0);
      compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL beq_mw: got %b want 0", mem_write); end
      tick();
      exp_pc = here;
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL beq_taken_pc: got %h want %h", pc, exp_pc); end
      drive(32'h1AFFFFFE, 32'h0);
      tick();
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL bne_not_taken_pc: got %h want %h", pc, exp_pc); end
      drive(32'h4A000002, 32'h0);
      tick();
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL bmi_not_taken_pc: got %h want %h", pc, exp_pc); end
      here = exp_pc;
      drive(32'hEA000002, 32'h0);
      tick();
      exp_pc = here + 32'd16;
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL bal_fwd_pc: got %h want %h", pc, exp_pc); end
      here = exp_pc;
      drive(32'hEAFFFFFB, 32'h0);
      tick();
      exp_pc = here - 32'd12;
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL bal_back_pc: got %h want %h", pc, exp_pc); end
      here = exp_pc;
      drive(32'hEB000000, 32'h0);
      tick();
      exp_pc = here + 32'd8;
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL bl_pc: got %h want %h", pc, exp_pc); end
   endtask

   task automatic test_alu();
      drive(32'hE28420FF, 32'h0);
      compared++; if (direction !== 32'h000000FF) begin mismatched++; $display("FAIL add_imm_dir: got %h want %h", direction, 32'hFF); end
      tick();
      drive(32'hE284310F, 32'h0);
      compared++; if (direction !== 32'hC0000003) begin mismatched++; $display("FAIL add_rot_dir: got %h want %h", direction, 32'hC0000003); end
      tick();
      drive(32'hE1826003, 32'h0);
      compared++; if (direction !== 32'hC00000FF) begin mismatched++; $display("FAIL orr_reg_dir: got %h want %h", direction, 32'hC00000FF); end
      tick();
      drive(32'hE0067202, 32'h0);
      compared++; if (direction !== 32'h000000F0) begin mismatched++; $display("FAIL and_lsl_dir: got %h want %h", direction, 32'hF0); end
      tick();
      drive(32'hE0428007, 32'h0);
      compared++; if (direction !== 32'h0000000F) begin mismatched++; $display("FAIL sub_reg_dir: got %h want %h", direction, 32'h0F); end
      tick();
      drive(32'hE5848000, 32'h0);
      compared++; if (write_data !== 32'h0000000F) begin mismatched++; $display("FAIL alu_r8: got %h want %h", write_data, 32'h0F); end
      tick();
      drive(32'hE5846000, 32'h0);
      compared++; if (write_data !== 32'hC00000FF) begin mismatched++; $display("FAIL alu_r6: got %h want %h", write_data, 32'hC00000FF); end
      tick();
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL alu_pc: got %h want %h", pc, exp_pc); end
   endtask

   task automatic test_flags();
      drive(32'hE093A003, 32'h0);
      compared++; if (direction !== 32'h80000006) begin mismatched++; $display("FAIL adds1_dir: got %h want %h", direction, 32'h80000006); end
      tick();
      drive(32'h4284B001, 32'h0); tick();
      drive(32'h5284B002, 32'h0); tick();
      drive(32'h7284C003, 32'h0); tick();
      drive(32'hE584B000, 32'h0);
      compared++; if (write_data !== 32'h1) begin mismatched++; $display("FAIL cond_mi_pl: got %h want %h", write_data, 32'h1); end
      tick();
      drive(32'hE584C000, 32'h0);
      compared++; if (write_data !== 32'h3) begin mismatched++; $display("FAIL cond_vc: got %h want %h", write_data, 32'h3); end
      tick();
      drive(32'hE09AA00A, 32'h0);
      compared++; if (direction !== 32'h0000000C) begin mismatched++; $display("FAIL adds_ovf_dir: got %h want %h", direction, 32'hC); end
      tick();
      drive(32'hE212D000, 32'h0); tick();
      drive(32'h6284B005, 32'h0); tick();
      drive(32'h2284C006, 32'h0); tick();
      drive(32'h1284B007, 32'h0); tick();
      drive(32'hB284D009, 32'h0); tick();
      drive(32'hE584B000, 32'h0);
      compared++; if (write_data !== 32'h5) begin mismatched++; $display("FAIL ands_keeps_v: got %h want %h", write_data, 32'h5); end
      tick();
      drive(32'hE584C000, 32'h0);
      compared++; if (write_data !== 32'h6) begin mismatched++; $display("FAIL ands_keeps_c: got %h want %h", write_data, 32'h6); end
      tick();
      drive(32'hE584D000, 32'h0);
      compared++; if (write_data !== 32'h9) begin mismatched++; $display("FAIL cond_lt: got %h want %h", write_data, 32'h9); end
      tick();
      drive(32'hE1521007, 32'h0);
      compared++; if (direction !== 32'h0000000F) begin mismatched++; $display("FAIL cmp1_dir: got %h want %h", direction, 32'hF); end
      tick();
      drive(32'h8284B008, 32'h0); tick();
      drive(32'h9284C009, 32'h0); tick();
      drive(32'hD284B00A, 32'h0); tick();
      drive(32'hC284D00B, 32'h0); tick();
      drive(32'hE584B000, 32'h0);
      compared++; if (write_data !== 32'h8) begin mismatched++; $display("FAIL cond_hi_le: got %h want %h", write_data, 32'h8); end
      tick();
      drive(32'hE584C000, 32'h0);
      compared++; if (write_data !== 32'h6) begin mismatched++; $display("FAIL cond_ls: got %h want %h", write_data, 32'h6); end
      tick();
      drive(32'hE584D000, 32'h0);
      compared++; if (write_data !== 32'hB) begin mismatched++; $display("FAIL cond_gt: got %h want %h", write_data, 32'hB); end
      tick();
      drive(32'hE1571002, 32'h0);
      compared++; if (direction !== 32'hFFFFFFF1) begin mismatched++; $display("FAIL cmp2_dir: got %h want %h", direction, 32'hFFFFFFF1); end
      tick();
      drive(32'h3284C011, 32'h0); tick();
      drive(32'hA284B012, 32'h0); tick();
      drive(32'hE234B0FF, 32'h0); tick();
      drive(32'h4284D021, 32'h0); tick();
      drive(32'hE584C000, 32'h0);
      compared++; if (write_data !== 32'h11) begin mismatched++; $display("FAIL cond_cc: got %h want %h", write_data, 32'h11); end
      tick();
      drive(32'hE584B000, 32'h0);
      compared++; if (write_data !== 32'h8) begin mismatched++; $display("FAIL cond_ge_eor: got %h want %h", write_data, 32'h8); end
      tick();
      drive(32'hE584D000, 32'h0);
      compared++; if (write_data !== 32'h21) begin mismatched++; $display("FAIL eor_no_flags: got %h want %h", write_data, 32'h21); end
      tick();
      drive(32'hE5841000, 32'h0);
      compared++; if (write_data !== 32'h12345678) begin mismatched++; $display("FAIL cmp_no_rd: got %h want %h", write_data, 32'h12345678); end
      tick();
      drive(32'h05841000, 32'h0);
      compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL streq_false_mw: got %b want 0", mem_write); end
      tick();
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL flags_pc: got %h want %h", pc, exp_pc); end
   endtask

   task automatic test_r15();
      logic [31:0] r2_val;
      r2_val = exp_pc + 32'd8;
      drive(32'hE28F2000, 32'h0);
      compared++; if (direction !== r2_val) begin mismatched++; $display("FAIL r15_read_dir: got %h want %h", direction, r2_val); end
      tick();
      drive(32'hE584F000, 32'h0);
      compared++; if (write_data !== exp_pc + 32'd8) begin mismatched++; $display("FAIL r15_str_wd: got %h want %h", write_data, exp_pc + 32'd8); end
      tick();
      drive(32'hE284F040, 32'h0);
      compared++; if (direction !== 32'h40) begin mismatched++; $display("FAIL r15_write_dir: got %h want %h", direction, 32'h40); end
      tick();
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL r15_write_ignored: got %h want %h", pc, exp_pc); end
      drive(32'hE5842000, 32'h0);
      compared++; if (write_data !== r2_val) begin mismatched++; $display("FAIL r15_r2: got %h want %h", write_data, r2_val); end
      tick();
   endtask

   task automatic test_async_reset();
      drive(32'hE5049004, 32'h0);
      reset = 1'b0;
      #1;
      compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL async_pc: got %h want %h", pc, 32'h0); end
      compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL async_mw: got %b want 0", mem_write); end
      @(posedge clk);
      #1;
      compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL async_pc_hold: got %h want %h", pc, 32'h0); end
      reset = 1'b1;
      exp_pc = 32'h0;
      drive(32'hE584F000, 32'h0);
      compared++; if (write_data !== 32'h8) begin mismatched++; $display("FAIL async_r15: got %h want %h", write_data, 32'h8); end
      tick();
      drive(32'hE5842000, 32'h0);
      compared++; if (write_data !== 32'h0) begin mismatched++; $display("FAIL async_r2_cleared: got %h want %h", write_data, 32'h0); end
      tick();
      drive(32'h0284B001, 32'h0);
      tick();
      drive(32'hE584B000, 32'h0);
      compared++; if (write_data !== 32'h0) begin mismatched++; $display("FAIL async_z_cleared: got %h want %h", write_data, 32'h0); end
      tick();
      compared++; if (pc !== exp_pc) begin mismatched++; $display("FAIL async_pc_run: got %h want %h", pc, exp_pc); end
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      exp_pc      = 32'h0;
      reset       = 1'b0;
      instruction = 32'h0;
      read_data   = 32'h0;
      test_reset();
      test_ldr();
      test_str();
      test_branch();
      test_alu();
      test_flags();
      test_r15();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
